// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port static RAM arbiter.
// MEM_ARB_FIXED_PRI_EN (optional) selects fixed priority inside rr_arb2.
package mem_arb_pkg;

  localparam int WORD_SIZE_DEF  = 16;
  localparam int ADDR_WIDTH_DEF = 16;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way request picker with a round-robin pointer.
// Build with MEM_ARB_FIXED_PRI_EN for fixed priority (port 0 wins, no pointer).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant,
  output logic       any
);

  assign any = |req;

`ifdef MEM_ARB_FIXED_PRI_EN
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, advance};

  always_comb begin
    grant = ~req[0] & req[1];
  end
`else
  // ptr_q names the port preferred on the next simultaneous request
  logic ptr_q, ptr_d;

  always_comb begin
    if (req[0] && req[1]) begin
      grant = ptr_q;
    end else begin
      grant = req[1];
    end
    ptr_d = ptr_q;
    if (advance && any) begin
      ptr_d = ~grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one static RAM between an instruction-fetch port and a data port.
// Arbitration mode follows MEM_ARB_FIXED_PRI_EN (see rr_arb2).
//
// state  | meaning
// IDLE   | waiting for a request; winner's addr/data/we captured on exit
// ADDR   | mem_clk2 high, memory latches mem_addr
// SETUP  | mem_rd/mem_wr settle before the access strobe
// ACCESS | mem_clk1 high, memory performs the read or write
// DONE   | ack to the granted port, read data presented on rdata
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WordSize  = WORD_SIZE_DEF,
  parameter int AddrWidth = ADDR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [AddrWidth-1:0] addr0,
  input  logic [WordSize-1:0]  wdata0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [AddrWidth-1:0] addr1,
  input  logic [WordSize-1:0]  wdata1,
  output logic                 ack1,
  output logic [WordSize-1:0]  rdata,
  output logic                 gnt_id,
  output logic                 busy,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [WordSize-1:0]  mem_din,
  input  logic [WordSize-1:0]  mem_dout,
  output logic                 mem_clk1,
  output logic                 mem_clk2,
  output logic                 mem_rd,
  output logic                 mem_wr
);

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  mem_addr_q, mem_addr_d;
  logic [WordSize-1:0]   mem_din_q, mem_din_d;
  logic [WordSize-1:0]   rdata_q, rdata_d;
  logic                  we_q, we_d;
  logic                  gnt_q, gnt_d;
  logic                  busy_q, busy_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  clk1_q, clk1_d;
  logic                  clk2_q, clk2_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;

  logic arb_grant, arb_any, arb_adv;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1, req0}),
    .advance (arb_adv),
    .grant   (arb_grant),
    .any     (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    we_d       = we_q;
    gnt_d      = gnt_q;
    rdata_d    = rdata_q;
    arb_adv    = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          arb_adv = 1'b1;
          gnt_d   = arb_grant;
          if (arb_grant == PORT_DATA) begin
            mem_addr_d = addr1;
            mem_din_d  = wdata1;
            we_d       = we1;
          end else begin
            mem_addr_d = addr0;
            mem_din_d  = wdata0;
            we_d       = we0;
          end
          state_d = ADDR;
        end
      end
      ADDR:   state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // memory drove mem_dout on the clk1 strobe of this state
        if (!we_q) begin
          rdata_d = mem_dout;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they arrive registered
    busy_d = (state_d != IDLE);
    clk2_d = (state_d == ADDR);
    clk1_d = (state_d == ACCESS);
    rd_d   = ((state_d == SETUP) || (state_d == ACCESS)) && !we_d;
    wr_d   = ((state_d == SETUP) || (state_d == ACCESS)) && we_d;
    ack0_d = (state_d == DONE) && (gnt_d == PORT_IFETCH);
    ack1_d = (state_d == DONE) && (gnt_d == PORT_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      gnt_q      <= 1'b0;
      busy_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      clk1_q     <= 1'b0;
      clk2_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      clk1_q     <= clk1_d;
      clk2_q     <= clk2_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign gnt_id   = gnt_q;
  assign busy     = busy_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_clk1 = clk1_q;
  assign mem_clk2 = clk2_q;
  assign mem_rd   = rd_q;
  assign mem_wr   = wr_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester controller that shares one staticram instance (address latched on clk2 rising edge, access on clk1 rising edge) between port 0 (instruction fetch) and port 1 (data load/store).
- Runs from a single system clock and generates the memory's clk2/clk1 strobes and RD/WR levels.
- Returns read data and a per-port completion pulse.

Parameters:
- WordSize, 16, data width in bits
- AddrWidth, 16, address width in bits

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request level
- we0  in  1  port 0 write enable (1 = write, 0 = read)
- addr0  in  AddrWidth  port 0 address
- wdata0  in  WordSize  port 0 write data
- ack0  out  1  port 0 completion pulse, one cycle
- req1, we1, addr1, wdata1, ack1  same as port 0, for port 1
- rdata  out  WordSize  read data; valid in the ack cycle
- gnt_id  out  1  index of the port owning the current transaction
- busy  out  1  high whenever state != IDLE
- mem_addr  out  AddrWidth  to staticram Addr
- mem_din  out  WordSize  to staticram DataIn
- mem_dout  in  WordSize  from staticram DataOut
- mem_clk1  out  1  access strobe to staticram clk1
- mem_clk2  out  1  address strobe to staticram clk2
- mem_rd  out  1  to staticram RD
- mem_wr  out  1  to staticram WR

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0 (ack0, ack1, rdata, gnt_id, busy, mem_addr, mem_din, mem_clk1, mem_clk2, mem_rd, mem_wr); round-robin pointer prefers port 0.
- Reset asserted mid-transaction: the transaction is abandoned with no ack. A write is not guaranteed to have landed.
- All outputs are registered, so strobes are glitch-free.
- FSM states: IDLE, ADDR, SETUP, ACCESS, DONE.
- IDLE:
  - If any req is high, pick a winner and register its addr/wdata/we into mem_addr/mem_din/we_q; set gnt_id; go to ADDR.
  - If no req is high, stay in IDLE.
- ADDR: mem_clk2=1 for one cycle; memory latches mem_addr. Go to SETUP.
- SETUP: mem_clk2=0; mem_rd=~we_q, mem_wr=we_q. Go to ACCESS.
- ACCESS: mem_clk1=1 for one cycle; mem_rd/mem_wr held. Go to DONE.
- DONE:
  - mem_clk1=0; mem_rd=mem_wr=0.
  - For a read, rdata <= mem_dout. For a write, rdata is unchanged.
  - ack[gnt_id]=1 for this cycle only. Go to IDLE.
- Latency: req sampled in IDLE at cycle N gives ack in cycle N+4. Throughput is one transaction per 5 cycles.
- Invariants:
  - mem_rd & mem_wr is never 1.
  - mem_clk1 and mem_clk2 are never high together.
  - mem_clk1 is only pulsed with exactly one of mem_rd/mem_wr high, so the memory's X-output branch is never exercised.
  - mem_addr and mem_din are stable from ADDR through DONE.
- Handshake:
  - The requester holds req, we, addr and wdata stable until ack.
  - Inputs are captured in IDLE only.
  - req dropped early: the captured transaction still completes and acks.
  - req still high in the cycle after ack: treated as a new request.
- Arbitration:
  - Round-robin. If both req are high in IDLE, the port not granted last wins.
  - The pointer updates only on grant.
  - If only one req is high, that port wins regardless of the pointer.
- rdata holds its last read value until the next read completes.

Optional Feature:
- MEM_ARB_FIXED_PRI_EN defined: fixed priority, port 0 always wins a simultaneous request; the round-robin pointer is removed.
- Not defined: round-robin as specified above.

Decomposition:
- Package mem_arb_pkg:
  - FSM state enum (IDLE/ADDR/SETUP/ACCESS/DONE, 3-bit encoding)
  - port index constants PORT_IFETCH=0, PORT_DATA=1
  - default WordSize/AddrWidth localparams
- Sub-module rr_arb2: 2-way picker with a pointer register on clk/rst_n.
  - Inputs: req[1:0], advance.
  - Outputs: grant index, any.
  - The fixed-priority macro is handled inside rr_arb2.
- Bench instantiates mem_arbiter connected to staticram, with mem_init.list preloaded.

Test Plan:
- Reset: hold rst_n=0 while req0=1 -> all outputs 0, no mem_clk1/mem_clk2 pulses; release -> grant follows on the next IDLE cycle.
- Single read: port 0 reads addr 10 (preload 16'h1234) -> mem_clk2 at N+1, mem_rd at N+2..N+3, mem_clk1 at N+3, ack0 and rdata=16'h1234 at N+4.
- Write then read: port 1 writes 16'h06CF to addr 2 (ack1 at N+4), then reads addr 2 -> rdata=16'h06CF; mem_wr never overlaps mem_rd.
- Contention: req0=req1=1 continuously, reads of addr 1 and addr 10 -> gnt_id alternates 0,1,0,1; one ack every 5 cycles; under MEM_ARB_FIXED_PRI_EN only ack0 pulses.
- Early drop and reset mid-op: req1 drops in ADDR -> ack1 still pulses at N+4; rst_n=0 in ACCESS -> outputs 0 immediately, no ack, state IDLE.
- Stability checker throughout: mem_addr/mem_din constant from ADDR to DONE; never clk1&clk2 both high; never rd&wr both high.
